mem_port_arbiter: RTL and testbench

- Shares the single 64-bit memory port between instruction fetch (IFU, read-only) and load/store (LSU, read/write) in the multi-cycle core.
- Arbitrates between the two requesters and keeps exactly one transaction outstanding.
- Sequences each transaction through request and response phases.
- Returns an error response if memory does not complete a transaction within a bounded time.

---
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction fetch unit (read-only) and
// the load/store unit (read/write). At most one transaction is in flight; it
// is arbitrated in IDLE, presented to memory in REQ, and awaits the memory
// response in RESP. A transaction that outlives its cycle budget completes
// with an error response.
//
// Ports:
//   clk, rst                    clock; asynchronous active-low reset
//   ifu_req_* / ifu_addr        IFU read request (ready is combinational, IDLE only)
//   ifu_rsp_valid/err/rdata     IFU one-cycle response pulse, err and data held
//   lsu_req_* / lsu_addr/wen/wdata/wmask   LSU request (ready combinational, IDLE only)
//   lsu_rsp_valid/err/rdata     LSU one-cycle response pulse, err and data held
//   mem_req_* / mem_addr/wen/wdata/wmask   request to memory, held stable in REQ
//   mem_rsp_valid / mem_rdata   memory response (read data or write ack)
//   busy                        transaction in REQ or RESP
//   grant_lsu                   owner of the current or last grant (1 = LSU)
module mem_port_arbiter #(
    parameter int unsigned AW      = 64,
    parameter int unsigned DW      = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_rsp_valid,
    output logic            ifu_rsp_err,
    output logic [DW-1:0]   ifu_rdata,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_addr,
    input  logic            lsu_wen,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wmask,
    output logic            lsu_rsp_valid,
    output logic            lsu_rsp_err,
    output logic [DW-1:0]   lsu_rdata,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_rsp_valid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy,
    output logic            grant_lsu
);

    localparam int unsigned MW = DW / 8;
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // cnt holds (cycles spent in REQ/RESP) - 1; tripping at TIMEOUT-2 puts
    // the error pulse TIMEOUT cycles after acceptance.
    localparam logic [CW-1:0] CNT_TRIP = CW'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic            tmo_c;
    logic            accept_c;
    logic            lsu_win_c;
    logic            done_ok_c;
    logic            done_err_c;

    assign tmo_c         = (cnt == CNT_TRIP);
    assign mem_req_valid = (state == S_REQ);
    assign busy          = (state != S_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, round-robin arbitration, handshakes and completion events
    always_comb begin
        state_next    = state;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        accept_c      = 1'b0;
        lsu_win_c     = 1'b0;
        done_ok_c     = 1'b0;
        done_err_c    = 1'b0;
        case (state)
            S_IDLE: begin
                // ready is gated by rst so every output reads 0 while in reset
                if (rst) begin
                    lsu_win_c     = lsu_req_valid & (~ifu_req_valid | ~grant_lsu);
                    lsu_req_ready = lsu_win_c;
                    ifu_req_ready = ifu_req_valid & ~lsu_win_c;
                    accept_c      = ifu_req_valid | lsu_req_valid;
                end
                if (accept_c) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (tmo_c) begin
                    done_err_c = 1'b1;
                    state_next = S_IDLE;
                end else if (mem_req_ready) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                // a real response beats a simultaneous timeout
                if (mem_rsp_valid) begin
                    done_ok_c  = 1'b1;
                    state_next = S_IDLE;
                end else if (tmo_c) begin
                    done_err_c = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Request capture, grant history and timeout counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            grant_lsu <= 1'b0;
            cnt       <= '0;
        end else begin
            if (accept_c) begin
                grant_lsu <= lsu_win_c;
                cnt       <= '0;
                if (lsu_win_c) begin
                    mem_addr  <= lsu_addr;
                    mem_wen   <= lsu_wen;
                    mem_wdata <= lsu_wdata;
                    mem_wmask <= lsu_wmask;
                end else begin
                    mem_addr  <= ifu_addr;
                    mem_wen   <= 1'b0;
                    mem_wdata <= ifu_wdata_zero();
                    mem_wmask <= MW'(0);
                end
            end else if (state != S_IDLE) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    function automatic logic [DW-1:0] ifu_wdata_zero();
        return '0;
    endfunction

    // Response registers: one-cycle valid pulse, err/data held until next
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifu_rsp_valid <= 1'b0;
            ifu_rsp_err   <= 1'b0;
            ifu_rdata     <= '0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_err   <= 1'b0;
            lsu_rdata     <= '0;
        end else begin
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            if (done_ok_c || done_err_c) begin
                if (grant_lsu) begin
                    lsu_rsp_valid <= 1'b1;
                    lsu_rsp_err   <= done_err_c;
                    lsu_rdata     <= (done_ok_c && !mem_wen) ? mem_rdata : '0;
                end else begin
                    ifu_rsp_valid <= 1'b1;
                    ifu_rsp_err   <= done_err_c;
                    ifu_rdata     <= done_ok_c ? mem_rdata : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT = 8).
module tb_mem_port_arbiter;

    localparam int unsigned AW      = 64;
    localparam int unsigned DW      = 64;
    localparam int unsigned MW      = DW / 8;
    localparam int unsigned TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_addr;
    logic          ifu_rsp_valid;
    logic          ifu_rsp_err;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid;
    logic          lsu_req_ready;
    logic [AW-1:0] lsu_addr;
    logic          lsu_wen;
    logic [DW-1:0] lsu_wdata;
    logic [MW-1:0] lsu_wmask;
    logic          lsu_rsp_valid;
    logic          lsu_rsp_err;
    logic [DW-1:0] lsu_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          grant_lsu;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_err   (ifu_rsp_err),
        .ifu_rdata     (ifu_rdata),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_err   (lsu_rsp_err),
        .lsu_rdata     (lsu_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .grant_lsu     (grant_lsu)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Called in the REQ cycle: zero-wait handshake, response next cycle.
    // Returns settled in the cycle of the response pulse.
    task automatic do_mem(input logic [63:0] rd);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = rd;
        tick();
        mem_rsp_valid = 1'b0;
        settle();
    endtask

    // Reset with both requesters valid; every output must read 0.
    task automatic apply_reset();
        rst           = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        tick();
        tick();
        check("rst_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
        check("rst_ctrl", {59'd0, mem_req_valid, busy, grant_lsu, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
        check("rst_err", {62'd0, ifu_rsp_err, lsu_rsp_err}, 64'd0);
        check("rst_ifu_rdata", ifu_rdata, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        rst           = 1'b1;
        tick();
    endtask

    initial begin
        rst           = 1'b0;
        ifu_req_valid = 1'b0;
        ifu_addr      = '0;
        lsu_req_valid = 1'b0;
        lsu_addr      = '0;
        lsu_wen       = 1'b0;
        lsu_wdata     = '0;
        lsu_wmask     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        apply_reset();

        // IFU read with zero-wait memory
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_0000;
        mem_req_ready = 1'b1;
        settle();
        check("t1_ifu_ready", {63'd0, ifu_req_ready}, 64'd1);
        check("t1_lsu_ready", {63'd0, lsu_req_ready}, 64'd0);
        check("t1_no_mreq_n", {63'd0, mem_req_valid}, 64'd0);
        tick();
        ifu_req_valid = 1'b0;
        settle();
        check("t1_mreq_n1", {62'd0, mem_req_valid, busy}, 64'd3);
        check("t1_maddr", mem_addr, 64'h8000_0000);
        check("t1_mwen", {63'd0, mem_wen}, 64'd0);
        check("t1_grant", {63'd0, grant_lsu}, 64'd0);
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'hDEAD_BEEF;
        settle();
        check("t1_mreq_n2", {63'd0, mem_req_valid}, 64'd0);
        check("t1_no_early_rsp", {63'd0, ifu_rsp_valid}, 64'd0);
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        check("t1_rsp_n3", {61'd0, ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid}, 64'd4);
        check("t1_rdata", ifu_rdata, 64'hDEAD_BEEF);
        check("t1_idle", {63'd0, busy}, 64'd0);
        tick();
        check("t1_pulse_end", {63'd0, ifu_rsp_valid}, 64'd0);
        check("t1_rdata_hold", ifu_rdata, 64'hDEAD_BEEF);

        // Round-robin ties: LSU, IFU, LSU
        apply_reset();
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h0000_0A00;
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h0000_0100;
        lsu_wen       = 1'b0;
        settle();
        check("t2_tie1_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd1);
        tick();
        lsu_req_valid = 1'b0;
        settle();
        check("t2_tie1_grant", {63'd0, grant_lsu}, 64'd1);
        check("t2_tie1_addr", mem_addr, 64'h0000_0100);
        check("t2_busy_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
        do_mem(64'h55);
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h0000_0200;
        settle();
        check("t2_lsu_rsp", {62'd0, lsu_rsp_valid, ifu_rsp_valid}, 64'd2);
        check("t2_lsu_rdata", lsu_rdata, 64'h55);
        check("t2_tie2_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd2);
        tick();
        ifu_req_valid = 1'b0;
        settle();
        check("t2_tie2_grant", {63'd0, grant_lsu}, 64'd0);
        check("t2_tie2_addr", mem_addr, 64'h0000_0A00);
        do_mem(64'h66);
        ifu_req_valid = 1'b1;
        settle();
        check("t2_ifu_rsp", {62'd0, lsu_rsp_valid, ifu_rsp_valid}, 64'd1);
        check("t2_ifu_rdata", ifu_rdata, 64'h66);
        check("t2_tie3_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd1);
        tick();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        settle();
        check("t2_tie3_grant", {63'd0, grant_lsu}, 64'd1);
        check("t2_tie3_addr", mem_addr, 64'h0000_0200);
        do_mem(64'h77);
        check("t2_tie3_rdata", lsu_rdata, 64'h77);

        // LSU store with memory stalling three cycles
        tick();
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h8000_0010;
        lsu_wen       = 1'b1;
        lsu_wdata     = 64'h1122_3344_5566_7788;
        lsu_wmask     = 8'h0F;
        mem_req_ready = 1'b0;
        settle();
        check("t3_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd1);
        tick();
        lsu_req_valid = 1'b0;
        lsu_addr      = 64'hFFFF_0000;
        lsu_wen       = 1'b0;
        lsu_wdata     = 64'h0;
        lsu_wmask     = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            mem_req_ready = (i == 3);
            settle();
            check("t3_mreq", {63'd0, mem_req_valid}, 64'd1);
            check("t3_maddr", mem_addr, 64'h8000_0010);
            check("t3_mwdata", mem_wdata, 64'h1122_3344_5566_7788);
            check("t3_mwen_mask", {55'd0, mem_wen, mem_wmask}, {55'd0, 1'b1, 8'h0F});
            tick();
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'hFFFF;
        settle();
        check("t3_resp_mreq", {62'd0, mem_req_valid, lsu_rsp_valid}, 64'd0);
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        check("t3_rsp", {61'd0, lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid}, 64'd4);
        check("t3_rdata_zero", lsu_rdata, 64'd0);

        // Timeout: memory never responds
        tick();
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h0000_0300;
        mem_req_ready = 1'b1;
        settle();
        check("t4_ready", {63'd0, ifu_req_ready}, 64'd1);
        tick();
        ifu_req_valid = 1'b0;
        settle();
        check("t4_mreq", {63'd0, mem_req_valid}, 64'd1);
        tick();
        mem_req_ready = 1'b0;
        for (int k = 2; k <= 7; k++) begin
            settle();
            check("t4_wait", {62'd0, ifu_rsp_valid, busy}, 64'd1);
            tick();
        end
        settle();
        check("t4_err_pulse", {62'd0, ifu_rsp_valid, ifu_rsp_err}, 64'd3);
        check("t4_err_rdata", ifu_rdata, 64'd0);
        check("t4_idle", {62'd0, busy, mem_req_valid}, 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'h1234;
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        check("t4_late_drop", {61'd0, ifu_rsp_valid, lsu_rsp_valid, busy}, 64'd0);
        check("t4_err_hold", {63'd0, ifu_rsp_err}, 64'd1);

        // Reset in RESP, then a stray memory response
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h0000_0400;
        mem_req_ready = 1'b1;
        tick();
        ifu_req_valid = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        check("t5_in_resp", {62'd0, busy, mem_req_valid}, 64'd2);
        rst           = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        settle();
        check("t5_rst_ctrl", {59'd0, busy, mem_req_valid, grant_lsu, ifu_req_ready, lsu_req_ready}, 64'd0);
        check("t5_rst_err", {63'd0, ifu_rsp_err}, 64'd0);
        check("t5_rst_addr", mem_addr, 64'd0);
        tick();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        rst           = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'hBAD;
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        check("t5_no_rsp", {61'd0, ifu_rsp_valid, lsu_rsp_valid, busy}, 64'd0);
        check("t5_no_rdata", ifu_rdata, 64'd0);
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h0000_0500;
        lsu_wen       = 1'b0;
        settle();
        check("t5_tie_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd1);
        tick();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        settle();
        check("t5_grant", {63'd0, grant_lsu}, 64'd1);
        do_mem(64'h99);
        check("t5_lsu_rsp", {62'd0, lsu_rsp_valid, ifu_rsp_valid}, 64'd2);

        // Back-to-back IFU reads: acceptance every 3 cycles, with the pulse
        mem_req_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            ifu_req_valid = 1'b1;
            ifu_addr      = 64'h1000 + 64'(r * 8);
            settle();
            check("t6_accept", {63'd0, ifu_req_ready}, 64'd1);
            if (r > 0) begin
                check("t6_coincident", {63'd0, ifu_rsp_valid}, 64'd1);
                check("t6_rdata", ifu_rdata, 64'hA0 + 64'(r - 1));
            end
            tick();
            settle();
            check("t6_req", {62'd0, mem_req_valid, ifu_req_ready}, 64'd2);
            check("t6_addr", mem_addr, 64'h1000 + 64'(r * 8));
            tick();
            mem_rsp_valid = 1'b1;
            mem_rdata     = 64'hA0 + 64'(r);
            settle();
            check("t6_resp_noready", {63'd0, ifu_req_ready}, 64'd0);
            tick();
            mem_rsp_valid = 1'b0;
        end
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        settle();
        check("t6_last_pulse", {63'd0, ifu_rsp_valid}, 64'd1);
        check("t6_last_rdata", ifu_rdata, 64'hA3);
        tick();
        check("t6_end", {62'd0, ifu_rsp_valid, busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
